// File: rtl/led_value_formatter.sv
// Formats a binary count for an 8-digit seven-segment driver: sequential
// double-dabble to packed BCD (or hex passthrough) plus a leading-zero-blanked enable mask.
module led_value_formatter #(
    parameter int IN_W       = 27,
    parameter int MIN_DIGITS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            hex_mode,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic [31:0]     value,
    output logic [7:0]      enable,
    output logic            overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_BLANK = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    function automatic logic [7:0] min_mask(input int n);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    function automatic logic [7:0] blank_mask(input logic [31:0] word);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < MIN_DIGITS) || ((word >> (4 * i)) != 32'd0);
        end
        return m;
    endfunction

    function automatic logic [31:0] dd_adjust(input logic [31:0] bcd);
        logic [31:0] r;
        r = bcd;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [7:0] RST_MASK = min_mask(MIN_DIGITS);
    localparam logic [4:0] CNT_LOAD = 5'(IN_W - 1);

    state_t          r_state;
    logic [IN_W-1:0] r_bin;
    logic [31:0]     r_bcd;
    logic [4:0]      r_cnt;
    logic            r_hex;
    logic            r_big;
    logic [31:0]     r_word;
    logic [7:0]      r_mask;
    logic            r_ovf;
    logic [31:0]     w_adj;
    logic [31:0]     w_cand;

    assign w_adj = dd_adjust(r_bcd);

    // Candidate display word; anything that spilled past digit 7 saturates.
    always_comb begin
        w_cand = r_bcd;
        if (r_hex) begin
            w_cand = 32'(r_bin);
        end else if (r_big) begin
            w_cand = 32'h9999_9999;
        end else begin
            w_cand = r_bcd;
        end
    end

    // Conversion FSM with staged candidate and atomically published outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_bin    <= '0;
            r_bcd    <= 32'd0;
            r_cnt    <= 5'd0;
            r_hex    <= 1'b0;
            r_big    <= 1'b0;
            r_word   <= 32'd0;
            r_mask   <= RST_MASK;
            r_ovf    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            value    <= 32'd0;
            enable   <= RST_MASK;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    // busy is still high in the done cycle, so start is ignored there
                    if (start && !busy) begin
                        r_bin   <= bin_in;
                        r_hex   <= hex_mode;
                        r_bcd   <= 32'd0;
                        r_big   <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        busy    <= 1'b1;
                        r_state <= hex_mode ? S_BLANK : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[30:0], r_bin[IN_W-1]};
                    r_bin <= r_bin << 1;
                    r_big <= r_big | w_adj[31];
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    r_word  <= w_cand;
                    r_mask  <= blank_mask(w_cand);
                    r_ovf   <= ~r_hex & r_big;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    value    <= r_word;
                    enable   <= r_mask;
                    overflow <= r_ovf;
                    done     <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_value_formatter.sv
// Directed bench for led_value_formatter: latency, BCD/hex words, blanking,
// saturation, start-while-busy and reset-abort behaviour.
module tb_led_value_formatter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        hex_mode;
    logic [26:0] bin_in;
    logic        busy, done, overflow;
    logic [31:0] value;
    logic [7:0]  enable;
    logic        busy3, done3, overflow3;
    logic [31:0] value3;
    logic [7:0]  enable3;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int lat;
    int d0;

    led_value_formatter #(.IN_W(27), .MIN_DIGITS(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hex_mode(hex_mode),
        .bin_in(bin_in), .busy(busy), .done(done), .value(value),
        .enable(enable), .overflow(overflow)
    );

    led_value_formatter #(.IN_W(27), .MIN_DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .hex_mode(hex_mode),
        .bin_in(bin_in), .busy(busy3), .done(done3), .value(value3),
        .enable(enable3), .overflow(overflow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one conversion; optionally fire a stray start at cycle T+stray_k.
    task automatic do_conv(input logic hm, input logic [26:0] v, input int stray_k, output int l);
        l = -1;
        @(negedge clk);
        start = 1'b1; hex_mode = hm; bin_in = v;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) chk_eq("busy_t1", 32'(busy), 32'd1);
            if (stray_k != 0 && k == stray_k) begin
                start = 1'b1; hex_mode = 1'b0; bin_in = 27'd99;
            end
            if (done) begin
                l = k;
                chk_eq("busy_done", 32'(busy), 32'd1);
                break;
            end
        end
        start = 1'b0;
        if (l < 0) chk_eq("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; hex_mode = 1'b0; bin_in = 27'd0;
        repeat (2) @(negedge clk);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_value", value, 32'd0);
        chk_eq("rst_enable", 32'(enable), 32'h01);
        chk_eq("rst_ovf", 32'(overflow), 32'd0);
        chk_eq("rst_enable3", 32'(enable3), 32'h07);
        reset_n = 1'b1;

        // 1: decimal 12345
        do_conv(1'b0, 27'd12345, 0, lat);
        chk_eq("t1_lat", 32'(lat), 32'd30);
        chk_eq("t1_value", value, 32'h0001_2345);
        chk_eq("t1_enable", 32'(enable), 32'h1F);
        chk_eq("t1_ovf", 32'(overflow), 32'd0);
        chk_eq("t1_enable3", 32'(enable3), 32'h1F);
        @(negedge clk);
        chk_eq("t1_busy_after", 32'(busy), 32'd0);

        // 2: decimal zero
        do_conv(1'b0, 27'd0, 0, lat);
        chk_eq("t2_value", value, 32'd0);
        chk_eq("t2_enable", 32'(enable), 32'h01);
        chk_eq("t2_enable3", 32'(enable3), 32'h07);

        // 3: hex passthrough
        do_conv(1'b1, 27'h0AB_CDEF, 0, lat);
        chk_eq("t3_lat", 32'(lat), 32'd3);
        chk_eq("t3_value", value, 32'h00AB_CDEF);
        chk_eq("t3_enable", 32'(enable), 32'h3F);

        // 4: saturation boundary
        do_conv(1'b0, 27'd99_999_999, 0, lat);
        chk_eq("t4_max_value", value, 32'h9999_9999);
        chk_eq("t4_max_enable", 32'(enable), 32'hFF);
        chk_eq("t4_max_ovf", 32'(overflow), 32'd0);
        do_conv(1'b0, 27'd100_000_000, 0, lat);
        chk_eq("t4_sat_lat", 32'(lat), 32'd30);
        chk_eq("t4_sat_value", value, 32'h9999_9999);
        chk_eq("t4_sat_enable", 32'(enable), 32'hFF);
        chk_eq("t4_sat_ovf", 32'(overflow), 32'd1);
        repeat (3) @(negedge clk);
        chk_eq("t4_hold_ovf", 32'(overflow), 32'd1);
        chk_eq("t4_hold_value", value, 32'h9999_9999);
        do_conv(1'b1, 27'd5, 0, lat);
        chk_eq("t4_hex_ovf", 32'(overflow), 32'd0);
        chk_eq("t4_hex_value", value, 32'h0000_0005);
        chk_eq("t4_hex_enable", 32'(enable), 32'h01);

        // 5: start while busy ignored, start right after done accepted
        d0 = n_done;
        do_conv(1'b0, 27'd42, 5, lat);
        chk_eq("t5_lat", 32'(lat), 32'd30);
        chk_eq("t5_value", value, 32'h42);
        do_conv(1'b0, 27'd7, 0, lat);
        chk_eq("t5_next_lat", 32'(lat), 32'd30);
        chk_eq("t5_next_value", value, 32'h7);
        chk_eq("t5_done_count", 32'(n_done - d0), 32'd2);

        // 6: reset during SHIFT abandons the conversion
        @(negedge clk);
        start = 1'b1; hex_mode = 1'b0; bin_in = 27'd12345;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_eq("t6_busy", 32'(busy), 32'd0);
        chk_eq("t6_done", 32'(done), 32'd0);
        chk_eq("t6_value", value, 32'd0);
        chk_eq("t6_enable", 32'(enable), 32'h01);
        chk_eq("t6_ovf", 32'(overflow), 32'd0);
        d0 = n_done;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("t6_no_done", 32'(n_done - d0), 32'd0);
        chk_eq("t6_value_kept", value, 32'd0);
        do_conv(1'b0, 27'd900, 0, lat);
        chk_eq("t6_value900", value, 32'h900);
        chk_eq("t6_enable900", 32'(enable), 32'h07);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
